pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS core. Carries an arbitrary packed payload with a valid/ready handshake, a global cache-miss hold, a synchronous flush that inserts a bubble, and optional two-entry skid buffering for full throughput with registered ready. Sits between any two pipeline stages; one instance per stage boundary.

## Interface
- DATA_W, 32, payload width in bits (packed control plus datapath fields), minimum 1
- CLEAR_ON_FLUSH, 1, 1: flushed entries zero out_data (bubble equals NOP/control-zero); 0: out_data keeps its last value
- clk  in  1  stage clock; all state updates on the falling edge, as for every pipeline register in the core
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- hold  in  1  global stall (cache miss, i.e. not hit); freezes the stage
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload valid toward downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered payload
- occupancy  out  2  entries held, 0..2 (0..1 without skid)

## Operation
- Input transfer: in_valid & in_ready & !hold & !flush at a falling edge.
- Output transfer: out_valid & out_ready at a falling edge (out_valid already masked by hold).
- Storage: main slot drives out_data; skid slot (SKID build only) catches one beat when main is occupied and not draining. Strict FIFO order: main drains first, skid moves to main on the same edge main drains.
- States (SKID build): EMPTY (occ 0), ONE (main only), FULL (main+skid). EMPTY->ONE on input xfer; ONE->EMPTY on output xfer without input; ONE->FULL on input without output; ONE stays ONE on simultaneous in/out; FULL->ONE on output xfer (no input accepted in FULL).
- hold=1: in_ready=0, out_valid=0, no state change, contents preserved; on release outputs resume with identical data.
- flush=1: all slots invalidated at the edge, occupancy->0; if CLEAR_ON_FLUSH, out_data->0. Flush overrides hold and any same-edge input transfer (incoming beat dropped).
- Output-side transfer on a flush edge is still counted complete downstream; stage discards nonetheless.

## Timing
- Latency: beat accepted at edge N appears on out_data/out_valid after edge N; one edge per occupied slot ahead of it.
- Throughput: one beat per cycle sustained while out_ready=1 in both builds.
- in_ready (SKID build): registered, equals !FULL & !hold; no combinational path out_ready->in_ready.
- out_data, out_valid come from flops (out_valid AND !hold only).
- Reset (async assert, any time, incl. mid-transfer): out_valid=0, out_data=0, occupancy=0, all slots empty, in_ready=0 while rst=1; in_ready=1 from first edge after deassert with hold=0.
- Reset release is synchronised to the falling edge by the top-level reset bridge; this block does not re-synchronise.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined: two slots, FSM above, registered in_ready, occupancy up to 2.
- Not defined: main slot only; in_ready = (!main_valid | out_ready) & !hold (combinational), occupancy 0..1, skid logic absent. Handshake, hold, flush and reset semantics otherwise identical.

## Structure
- Shared package pipe_pkg: occupancy encodings (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2), NOP payload constant, stage payload struct widths used to compute DATA_W per boundary.
- Sub-module pipe_slot: one DATA_W register plus valid bit with load/clear/zero-on-clear controls; instantiated once (main) or twice (main, skid).

## Test plan
- Reset mid-stream: occupancy 2, assert rst between edges -> out_valid=0, out_data=0, occupancy=0 immediately; after release, in_ready=1 next edge.
- Backpressure: send 0x11,0x22,0x33 with out_ready=0 -> SKID build accepts 0x11,0x22, in_ready=0, occupancy=2; out_ready=1 -> outputs 0x11,0x22,0x33 in order, no loss/duplication.
- Hold: occupancy 1 with 0xAB, hold=1 for 5 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, nothing accepted; release -> 0xAB emitted once.
- Flush vs input: occupancy 2, flush=1 and in_valid=1 (0x55) same edge -> occupancy 0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), 0x55 never emitted.
- Streaming: 1000 random beats, random out_ready and in_valid, 10% hold -> scoreboard exact order match, one beat/cycle when out_ready=1 and hold=0, both macro builds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: occupancy encodings, slot states, NOP
// payload and the per-boundary payload structs that size each stage register.
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = OCC_EMPTY,
      ST_ONE   = OCC_ONE,
      ST_FULL  = OCC_FULL
   } slot_state_e;

   // sll $0,$0,0 encodes as all zeros, so a zeroed payload is a NOP
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_dst;
      logic        mem_rd;
      logic        mem_wr;
      logic        mem_to_reg;
      logic        reg_wr;
      logic [31:0] pc_plus4;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } id_ex_t;

   typedef struct packed {
      logic        mem_rd;
      logic        mem_wr;
      logic        mem_to_reg;
      logic        reg_wr;
      logic [31:0] alu_res;
      logic [31:0] st_data;
      logic [4:0]  wr_reg;
   } ex_mem_t;

   typedef struct packed {
      logic        mem_to_reg;
      logic        reg_wr;
      logic [31:0] rd_data;
      logic [31:0] alu_res;
      logic [4:0]  wr_reg;
   } mem_wb_t;

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

   function automatic logic [1:0] occ_of(slot_state_e s);
      case (s)
         ST_ONE:  return OCC_ONE;
         ST_FULL: return OCC_FULL;
         default: return OCC_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage boundary: upstream valid/ready/data,
// downstream valid/ready/data, global hold/flush and occupancy status.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32
);

   logic              hold;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   modport master (
      output hold, flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  hold, flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );

endinterface

// File: rtl/pipe_slot.sv
// One payload register plus valid bit, updated on the falling clock edge.
// Clear wins over load; zero_i selects whether a clear also zeroes the data.
module pipe_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic              clear_i,
   input  logic              zero_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         if (zero_i) data_d = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with hold, flush and valid/ready handshake.
// Define PIPE_STAGE_REG_SKID_EN for the two-slot skid build with registered in_ready.
//
// state    | meaning
// ST_EMPTY | no slot holds a beat
// ST_ONE   | main slot holds a beat, skid empty
// ST_FULL  | main and skid both hold beats, input blocked
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_reg_if.slave  bus
);

   logic              in_ready_w;
   logic              out_valid_w;
   logic              in_xfer;
   logic              out_xfer;
   logic              main_load;
   logic              main_unload;
   logic              main_valid;
   logic [DATA_W-1:0] main_din;
   logic [DATA_W-1:0] main_data;

   assign out_valid_w = main_valid & ~bus.hold;
   assign in_xfer     = bus.in_valid & in_ready_w & ~bus.flush;
   assign out_xfer    = out_valid_w & bus.out_ready;

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk      (clk),
      .rst      (rst),
      .load_i   (main_load),
      .unload_i (main_unload),
      .clear_i  (bus.flush),
      .zero_i   (CLEAR_ON_FLUSH),
      .data_i   (main_din),
      .valid_o  (main_valid),
      .data_o   (main_data)
   );

`ifdef PIPE_STAGE_REG_SKID_EN

   slot_state_e       state_d, state_q;
   logic              rdy_q;
   logic              main_sel_skid;
   logic              skid_load;
   logic              skid_unload;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;

   pipe_slot #(.DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (bus.flush),
      .zero_i   (CLEAR_ON_FLUSH),
      .data_i   (bus.in_data),
      .valid_o  (skid_valid),
      .data_o   (skid_data)
   );

   // skid_valid mirrors ST_FULL; the state register is the authority
   logic unused_skid_valid;
   assign unused_skid_valid = skid_valid;

   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      main_unload   = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_unload   = 1'b0;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_load = 1'b1;
               end else if (in_xfer) begin
                  state_d   = ST_FULL;
                  skid_load = 1'b1;
               end else if (out_xfer) begin
                  state_d     = ST_EMPTY;
                  main_unload = 1'b1;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  state_d       = ST_ONE;
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_unload   = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != ST_FULL);
      end
   end

   assign main_din      = main_sel_skid ? skid_data : bus.in_data;
   assign in_ready_w    = rdy_q & ~bus.hold;
   assign bus.occupancy = occ_of(state_q);

`else

   logic live_q;

   // keeps in_ready low until the first edge after reset release
   always_ff @(negedge clk or posedge rst) begin
      if (rst) live_q <= 1'b0;
      else     live_q <= 1'b1;
   end

   assign main_load     = in_xfer;
   assign main_unload   = out_xfer & ~in_xfer;
   assign main_din      = bus.in_data;
   assign in_ready_w    = live_q & (~main_valid | bus.out_ready) & ~bus.hold;
   assign bus.occupancy = main_valid ? OCC_ONE : OCC_EMPTY;

`endif

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector and scoreboard bench for pipe_stage_reg (both builds).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif
   localparam int DEPTH = SKID ? 2 : 1;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   pipe_stage_reg_if #(.DATA_W(32)) bus ();

   pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic        hold;
      logic        flush;
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        e_irdy;
      logic        e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_occ;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic h, input logic f, input logic iv, input logic [31:0] id,
                        input logic ordy);
      bus.hold      = h;
      bus.flush     = f;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
   endtask

   task automatic edge_step();
      @(negedge clk);
      #1;
   endtask

   task automatic fill(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b1, base + 32'(i), 1'b0);
         #1;
         edge_step();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   logic [31:0] bp_list[3];
   logic [31:0] q[$];

   initial begin
      int k, got, cnt, cyc, sent;
      logic r, ov, irdy_e, ov_e;
      logic [31:0] od;

      vecs[0]  = '{0, 0, 1, 32'h11, 1, 1, 1, 32'h11, 2'd1};
      vecs[1]  = '{0, 0, 1, 32'h22, 1, 1, 1, 32'h22, 2'd1};
      vecs[2]  = '{0, 0, 0, 32'h00, 1, 1, 0, 32'h22, 2'd0};
      vecs[3]  = '{0, 0, 1, 32'h33, 0, 1, 1, 32'h33, 2'd1};
      vecs[4]  = '{1, 0, 1, 32'h44, 1, 0, 0, 32'h33, 2'd1};
      vecs[5]  = '{1, 0, 1, 32'h44, 1, 0, 0, 32'h33, 2'd1};
      vecs[6]  = '{0, 0, 1, 32'h44, 1, 1, 1, 32'h44, 2'd1};
      vecs[7]  = '{0, 1, 1, 32'h55, 1, 1, 0, 32'h00, 2'd0};
      vecs[8]  = '{1, 1, 0, 32'h00, 1, 0, 0, 32'h00, 2'd0};
      vecs[9]  = '{0, 0, 1, 32'h66, 1, 1, 1, 32'h66, 2'd1};
      vecs[10] = '{1, 1, 1, 32'h77, 1, 0, 0, 32'h00, 2'd0};
      vecs[11] = '{0, 0, 0, 32'h00, 1, 1, 0, 32'h00, 2'd0};
      bp_list[0] = 32'h11;
      bp_list[1] = 32'h22;
      bp_list[2] = 32'h33;

      // reset state
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      edge_step();
      edge_step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data", bus.out_data, 32'h0);
      chk("rst_occ", 32'(bus.occupancy), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      edge_step();
      chk("rel_in_ready", 32'(bus.in_ready), 32'h1);

      // directed vectors
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].hold, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
         edge_step();
         chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].e_od);
         chk($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
      end

      // backpressure then drain in order
      k = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, bp_list[k], 1'b0);
         #1;
         r = bus.in_ready;
         edge_step();
         if (r) k++;
      end
      chk("bp_accepted", 32'(k), 32'(DEPTH));
      chk("bp_occ", 32'(bus.occupancy), 32'(DEPTH));
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      got = 0;
      cyc = 0;
      while (got < 3 && cyc < 20) begin
         drive(1'b0, 1'b0, (k < 3), (k < 3) ? bp_list[k] : 32'h0, 1'b1);
         #1;
         r  = bus.in_ready;
         ov = bus.out_valid;
         od = bus.out_data;
         if (ov) begin
            chk($sformatf("bp_order%0d", got), od, bp_list[got]);
            got++;
         end
         edge_step();
         if (r && k < 3) k++;
         cyc++;
      end
      chk("bp_count", 32'(got), 32'd3);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_no_dup", 32'(bus.out_valid), 32'h0);
         edge_step();
      end

      // hold freezes the stage
      fill(1, 32'hAB);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'hCD, 1'b1);
         #1;
         chk("hold_out_valid", 32'(bus.out_valid), 32'h0);
         chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
         edge_step();
         chk("hold_occ", 32'(bus.occupancy), 32'h1);
      end
      cnt = 0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         if (bus.out_valid) begin
            cnt++;
            chk("hold_release_data", bus.out_data, 32'hAB);
         end
         edge_step();
      end
      chk("hold_emit_once", 32'(cnt), 32'h1);

      // flush overrides a same-edge input
      fill(2, 32'hA1);
      chk("flush_pre_occ", 32'(bus.occupancy), 32'(DEPTH));
      drive(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
      #1;
      edge_step();
      chk("flush_occ", 32'(bus.occupancy), 32'h0);
      chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
      chk("flush_out_data", bus.out_data, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("flush_no_emit", 32'(bus.out_valid), 32'h0);
         edge_step();
      end

      // asynchronous reset mid-stream
      fill(2, 32'hB1);
      drive(1'b0, 1'b0, 1'b1, 32'hBB, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_out_data", bus.out_data, 32'h0);
      chk("arst_occ", 32'(bus.occupancy), 32'h0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      edge_step();
      chk("arst_rel_in_ready", 32'(bus.in_ready), 32'h1);
      chk("arst_rel_occ", 32'(bus.occupancy), 32'h0);

      // random streaming against a queue scoreboard
      q.delete();
      sent = 0;
      cyc  = 0;
      while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
         drive(($urandom_range(0, 9) == 0), 1'b0,
               (sent < 1000) && ($urandom_range(0, 1) == 1), $urandom,
               ($urandom_range(0, 3) != 0));
         #1;
         ov_e   = (q.size() > 0) && !bus.hold;
         irdy_e = !bus.hold && (SKID ? (q.size() < 2) : (q.size() == 0 || bus.out_ready));
         chk("stream_out_valid", 32'(bus.out_valid), 32'(ov_e));
         chk("stream_in_ready", 32'(bus.in_ready), 32'(irdy_e));
         chk("stream_occ", 32'(bus.occupancy), 32'(q.size()));
         if (ov_e) chk("stream_data", bus.out_data, q[0]);
         if (ov_e && bus.out_ready) void'(q.pop_front());
         if (irdy_e && bus.in_valid) begin
            q.push_back(bus.in_data);
            sent++;
         end
         edge_step();
         cyc++;
      end
      chk("stream_done", 32'(cyc < 20000), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
